// File: rtl/mips_pkg.sv
// Shared decode constants and FSM state type for the EX-stage multiply/divide unit.
package mips_pkg;

    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_iter.sv
// Iteration datapath: one shift-add multiply step or one restoring-divide step per cycle
// on a 64-bit {upper, lower} register. Operands are unsigned magnitudes.
module muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic              load_div,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic [2*XLEN-1:0] acc_next
);

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic              div_q, div_d;
    logic [XLEN:0]     add_sum;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     diff;

    // Multiply: lower half holds the multiplier, shifted out LSB-first while the sum enters on top.
    // Divide: upper half is the partial remainder, quotient bits shift into the lower half.
    always_comb begin
        add_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
        rem_sh  = acc_q[2*XLEN-1:XLEN-1];
        diff    = rem_sh - {1'b0, b_q};
        if (div_q) begin
            if (!diff[XLEN]) begin
                acc_next = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end else begin
                acc_next = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_next = {add_sum, acc_q[XLEN-1:1]};
        end
    end

    always_comb begin
        acc_d = acc_q;
        b_d   = b_q;
        div_d = div_q;
        if (load) begin
            acc_d = {{XLEN{1'b0}}, a};
            b_d   = b;
            div_d = load_div;
        end else if (step) begin
            acc_d = acc_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            b_q   <= b_d;
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// EX-stage iterative multiply/divide unit owning HI/LO; stalls the pipeline while an
// operation iterates and serves mfhi/mflo/mthi/mtlo from IDLE.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic [1:0]      ALUOp,
    input  logic [5:0]      funct,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    output logic            stall,
    output logic            busy,
    output logic            mf_valid,
    output logic [XLEN-1:0] mf_result,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output state_e          dbg_state
);

    localparam int CNT_W = $clog2(XLEN);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              div_q, div_d;
    logic              neg_q, neg_d;
    logic              rneg_q, rneg_d;
    logic              dz_q, dz_d;
    logic [XLEN-1:0]   rs_q, rs_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;

    logic              dec_ok, is_start, is_div, is_signed, a_neg, b_neg, last;
    logic [XLEN-1:0]   a_mag, b_mag, quo, rem;
    logic [2*XLEN-1:0] acc_next, prod;

    // Instruction inputs only matter in IDLE; in BUSY/DONE the EX slot is the frozen muldiv.
    always_comb begin
        dec_ok    = ex_valid && (ALUOp == ALUOP_RTYPE) && (state_q == IDLE);
        is_start  = dec_ok && ((funct == FN_MULT) || (funct == FN_MULTU) ||
                               (funct == FN_DIV)  || (funct == FN_DIVU));
        is_div    = funct[1];
        is_signed = !funct[0];
        a_neg     = is_signed && rs_val[XLEN-1];
        b_neg     = is_signed && rt_val[XLEN-1];
        a_mag     = a_neg ? -rs_val : rs_val;
        b_mag     = b_neg ? -rt_val : rt_val;
    end

    muldiv_iter #(.XLEN(XLEN)) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (is_start),
        .step     (state_q == BUSY),
        .load_div (is_div),
        .a        (a_mag),
        .b        (b_mag),
        .acc_next (acc_next)
    );

    always_comb begin
        quo  = acc_next[XLEN-1:0];
        rem  = acc_next[2*XLEN-1:XLEN];
        prod = neg_q ? -acc_next : acc_next;
        last = (state_q == BUSY) && (cnt_q == CNT_W'(XLEN-1));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        rs_d    = rs_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (is_start) begin
                    div_d   = is_div;
                    neg_d   = a_neg ^ b_neg;
                    rneg_d  = is_div && a_neg;
                    dz_d    = is_div && (rt_val == '0);
                    rs_d    = rs_val;
                    cnt_d   = '0;
                    state_d = BUSY;
                end else if (dec_ok && (funct == FN_MTHI)) begin
                    hi_d = rs_val;
                end else if (dec_ok && (funct == FN_MTLO)) begin
                    lo_d = rs_val;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (last) begin
                    state_d = DONE;
                    // Divide by zero still runs the full iteration count, then is overridden.
                    if (dz_q) begin
                        hi_d = rs_q;
                        lo_d = '1;
                    end else if (div_q) begin
                        hi_d = rneg_q ? -rem : rem;
                        lo_d = neg_q ? -quo : quo;
                    end else begin
                        hi_d = prod[2*XLEN-1:XLEN];
                        lo_d = prod[XLEN-1:0];
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            rs_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            rs_q    <= rs_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        busy      = (state_q == BUSY);
        stall     = is_start || busy;
        mf_valid  = dec_ok && ((funct == FN_MFHI) || (funct == FN_MFLO));
        mf_result = '0;
        if (mf_valid) begin
            mf_result = (funct == FN_MFHI) ? hi_q : lo_q;
        end
        hi        = hi_q;
        lo        = lo_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized mult/div/mt/mf traffic
// compared against an arithmetic reference model.
module tb_muldiv_unit;
    import mips_pkg::*;

    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic [1:0]  alu_op = 2'b00;
    logic [5:0]  funct = 6'd0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        stall, busy, mf_valid;
    logic [31:0] mf_result, hi, lo;
    state_e      dbg_state;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp_q[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ex_valid  (ex_valid),
        .ALUOp     (alu_op),
        .funct     (funct),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .stall     (stall),
        .busy      (busy),
        .mf_valid  (mf_valid),
        .mf_result (mf_result),
        .hi        (hi),
        .lo        (lo),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference result as {hi, lo}, straight from the instruction semantics.
    function automatic logic [63:0] ref_muldiv(input logic [5:0] fn, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb;
        int          qi, ri;
        logic [63:0] r;
        case (fn)
            FN_MULT: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                r  = 64'(sa * sb);
            end
            FN_MULTU: r = {32'd0, a} * {32'd0, b};
            FN_DIV: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
                else begin
                    qi = $signed(a) / $signed(b);
                    ri = $signed(a) % $signed(b);
                    r  = {32'(ri), 32'(qi)};
                end
            end
            default: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else r = {a % b, a / b};
            end
        endcase
        return r;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'd1;
            4:       return 32'($urandom_range(0, 200));
            default: return $urandom;
        endcase
    endfunction

    // Issue a muldiv in IDLE and hold it in EX while stalled; returns sampling in the DONE cycle.
    task automatic run_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        int          cyc;
        logic [63:0] e;
        @(negedge clk);
        ex_valid = 1'b1;
        alu_op   = ALUOP_RTYPE;
        funct    = fn;
        rs_val   = a;
        rt_val   = b;
        exp_q.push_back(ref_muldiv(fn, a, b));
        #1;
        cyc = 0;
        while (stall && cyc < 100) begin
            cyc++;
            @(negedge clk);
            #1;
        end
        check("stall_cycles", 64'(cyc), 64'd33);
        check("done_busy", {63'd0, busy}, 64'd0);
        e = exp_q.pop_front();
        check("op_hi", {32'd0, hi}, {32'd0, e[63:32]});
        check("op_lo", {32'd0, lo}, {32'd0, e[31:0]});
        m_hi = e[63:32];
        m_lo = e[31:0];
    endtask

    task automatic move_to(input logic [5:0] fn, input logic [31:0] a, input logic ev,
                           input logic [1:0] op);
        @(negedge clk);
        ex_valid = ev;
        alu_op   = op;
        funct    = fn;
        rs_val   = a;
        rt_val   = $urandom;
        #1;
        check("mt_stall", {63'd0, stall}, 64'd0);
        if (ev && op == ALUOP_RTYPE) begin
            if (fn == FN_MTHI) m_hi = a;
            else m_lo = a;
        end
        @(posedge clk);
        #1;
        check("mt_hi", {32'd0, hi}, {32'd0, m_hi});
        check("mt_lo", {32'd0, lo}, {32'd0, m_lo});
    endtask

    task automatic move_from(input logic [5:0] fn, input logic ev, input logic [1:0] op);
        logic        exp_v;
        logic [31:0] exp_r;
        @(negedge clk);
        ex_valid = ev;
        alu_op   = op;
        funct    = fn;
        rs_val   = $urandom;
        rt_val   = $urandom;
        #1;
        exp_v = ev && (op == ALUOP_RTYPE);
        exp_r = exp_v ? ((fn == FN_MFHI) ? m_hi : m_lo) : 32'd0;
        check("mf_valid", {63'd0, mf_valid}, {63'd0, exp_v});
        check("mf_result", {32'd0, mf_result}, {32'd0, exp_r});
        check("mf_stall", {63'd0, stall}, 64'd0);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        ex_valid = 1'b0;
        funct    = 6'd0;
    endtask

    initial begin
        logic [5:0] fn;
        logic [5:0] start_fns[4];
        start_fns[0] = FN_MULT;
        start_fns[1] = FN_MULTU;
        start_fns[2] = FN_DIV;
        start_fns[3] = FN_DIVU;

        // Reset state, with a start-like instruction presented to prove it is held off.
        ex_valid = 1'b1;
        alu_op   = ALUOP_RTYPE;
        funct    = FN_MULT;
        rs_val   = 32'd5;
        rt_val   = 32'd7;
        #12;
        check("rst_stall", {63'd0, stall}, 64'd1);
        ex_valid = 1'b0;
        #1;
        check("rst_stall_idle", {63'd0, stall}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_mf_valid", {63'd0, mf_valid}, 64'd0);
        check("rst_mf_result", {32'd0, mf_result}, 64'd0);
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases.
        run_op(FN_MULT, 32'hFFFF_FFFD, 32'd5);
        idle_cycle();
        run_op(FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        move_from(FN_MFHI, 1'b1, ALUOP_RTYPE);
        idle_cycle();
        run_op(FN_DIV, 32'hFFFF_FFF9, 32'd2);
        run_op(FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        idle_cycle();
        run_op(FN_DIVU, 32'd7, 32'd0);
        run_op(FN_DIV, 32'hFFFF_FFF9, 32'd0);
        move_to(FN_MTHI, 32'h1234_5678, 1'b1, ALUOP_RTYPE);
        move_to(FN_MTLO, 32'h9ABC_DEF0, 1'b1, ALUOP_RTYPE);
        move_from(FN_MFLO, 1'b1, ALUOP_RTYPE);
        move_to(FN_MTHI, 32'hDEAD_BEEF, 1'b0, ALUOP_RTYPE);
        move_to(FN_MTLO, 32'hCAFE_F00D, 1'b1, 2'b00);
        move_from(FN_MFHI, 1'b0, ALUOP_RTYPE);
        move_from(FN_MFLO, 1'b1, 2'b01);
        idle_cycle();

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0: move_to(FN_MTHI, $urandom, 1'($urandom_range(0, 1)), ALUOP_RTYPE);
                1: move_to(FN_MTLO, $urandom, 1'b1, 2'($urandom_range(0, 3)));
                2: move_from($urandom_range(0, 1) ? FN_MFHI : FN_MFLO, 1'b1, ALUOP_RTYPE);
                default: begin
                    fn = start_fns[$urandom_range(0, 3)];
                    run_op(fn, pick_operand(), pick_operand());
                    if ($urandom_range(0, 1) == 1) idle_cycle();
                end
            endcase
        end
        idle_cycle();

        // Reset in the middle of a multiply.
        move_to(FN_MTHI, 32'h0000_1111, 1'b1, ALUOP_RTYPE);
        move_to(FN_MTLO, 32'h0000_1111, 1'b1, ALUOP_RTYPE);
        @(negedge clk);
        funct  = FN_MULT;
        rs_val = 32'd123;
        rt_val = 32'd456;
        repeat (11) @(negedge clk);
        check("mid_busy", {63'd0, busy}, 64'd1);
        rst_n    = 1'b0;
        ex_valid = 1'b0;
        #1;
        check("mid_rst_stall", {63'd0, stall}, 64'd0);
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        check("mid_rst_hi", {32'd0, hi}, 64'd0);
        check("mid_rst_lo", {32'd0, lo}, 64'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(FN_DIV, 32'd100, 32'd7);
        check("div_100_7_lo", {32'd0, lo}, 64'd14);
        check("div_100_7_hi", {32'd0, hi}, 64'd2);
        idle_cycle();
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
